// File: rtl/cosim_pkg.sv
// cosim_pkg: shared FSM state type, default polynomial and MISR fold function
// for the cosim response compactor.
package cosim_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [127:0] COSIM_MISR_POLY128 = 128'h87;
    // Operands are MSB-aligned in a wide vector so one function serves any WIDTH up to the max.
    localparam int MISR_MAX_W = 1024;
    typedef logic [MISR_MAX_W-1:0] misr_vec_t;
    function automatic misr_vec_t misr_step(input misr_vec_t sig, input misr_vec_t d, input misr_vec_t poly);
        return {sig[MISR_MAX_W-2:0], 1'b0} ^ (sig[MISR_MAX_W-1] ? poly : '0) ^ d;
    endfunction
endpackage

// File: rtl/cosim_misr_core.sv
// cosim_misr_core: signature register with seed load and fold-step enables.
module cosim_misr_core
    import cosim_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(COSIM_MISR_POLY128)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sig_next
);
    localparam int SH = MISR_MAX_W - WIDTH;
    logic [WIDTH-1:0] sig_q, sig_d;
    always_comb begin
        sig_next = WIDTH'(misr_step(misr_vec_t'(sig_q) << SH, misr_vec_t'(d) << SH,
                                    misr_vec_t'(POLY) << SH) >> SH);
        sig_d = load ? seed : step ? sig_next : sig_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= '0;
        else sig_q <= sig_d;
    end
    assign sig = sig_q;
endmodule

// File: rtl/cosim_resp_misr.sv
// cosim_resp_misr: folds NVEC handshaked response words into a MISR, counts
// words and X/Z-tainted words, and compares the final signature.
module cosim_resp_misr
    import cosim_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int NVEC = 256,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(COSIM_MISR_POLY128),
    parameter logic [WIDTH-1:0] SEED = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] exp_sig,
    output logic [WIDTH-1:0] sig_out,
    output logic [15:0]      vec_count,
    output logic [15:0]      x_count,
    output logic             busy,
    output logic             done,
    output logic             pass
);
    state_t state_q, state_d;
    logic [15:0] vec_q, vec_d, x_q, x_d;
    logic pass_q, pass_d, load, acc;
    logic [WIDTH-1:0] d_clean, sig_next;
    cosim_misr_core #(.WIDTH(WIDTH), .POLY(POLY)) u_core (
        .clk(clk), .rst(rst), .load(load), .step(acc), .seed(SEED),
        .d(d_clean), .sig(sig_out), .sig_next(sig_next)
    );
    always_comb begin
        for (int i = 0; i < WIDTH; i++) d_clean[i] = (in_data[i] === 1'b1);
        acc = in_valid && (state_q == RUN);
        load = start && (state_q != RUN);
        state_d = state_q;
        vec_d = vec_q;
        x_d = x_q;
        pass_d = pass_q;
        if (load) begin
            state_d = RUN;
            vec_d = '0;
            x_d = '0;
            pass_d = 1'b0;
        end else if (acc) begin
            vec_d = (vec_q == 16'hFFFF) ? vec_q : vec_q + 16'd1;
            x_d = ($isunknown(in_data) && x_q != 16'hFFFF) ? x_q + 16'd1 : x_q;
            if (vec_d == 16'(NVEC)) begin
                state_d = DONE;
                pass_d = (sig_next == exp_sig);
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q <= '0;
            x_q <= '0;
            pass_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q <= vec_d;
            x_q <= x_d;
            pass_q <= pass_d;
        end
    end
    assign busy = (state_q == RUN);
    assign in_ready = busy;
    assign done = (state_q == DONE);
    assign pass = pass_q;
    assign vec_count = vec_q;
    assign x_count = x_q;
endmodule

// File: tb/tb_cosim_resp_misr.sv
// tb_cosim_resp_misr: randomized runs against a behavioural MISR model with a
// queue-based scoreboard checked by an independent accept monitor.
module tb_cosim_resp_misr;
    localparam int W = 8;
    localparam int N = 4;
    localparam logic [W-1:0] P = 8'h1D;
    localparam logic [W-1:0] S = 8'h5A;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic in_ready, busy, done, pass;
    logic [W-1:0] in_data = '0, exp_sig = '0, sig_out;
    logic [15:0] vec_count, x_count;
    int checks = 0, errors = 0;

    typedef struct {
        logic [W-1:0] sig;
        int vec;
        int x;
        logic done;
        logic pass;
    } exp_t;
    exp_t q[$];
    exp_t e_mon;
    logic [W-1:0] m_sig;
    int m_vec, m_x;
    logic m_pass;

    cosim_resp_misr #(.WIDTH(W), .NVEC(N), .POLY(P), .SEED(S)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .exp_sig(exp_sig), .sig_out(sig_out), .vec_count(vec_count),
        .x_count(x_count), .busy(busy), .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Shift left, reduce modulo x^W via the polynomial, add the word with X/Z read as 0.
    function automatic logic [W-1:0] ref_fold(input logic [W-1:0] s, input logic [W-1:0] d);
        int t;
        logic [W-1:0] c;
        t = int'(s) * 2;
        for (int i = 0; i < W; i++) c[i] = (d[i] === 1'b1);
        return W'(t % 256) ^ ((t >= 256) ? P : 8'h00) ^ c;
    endfunction

    task automatic check_outputs(input string tag, input logic [W-1:0] s, input int v, input int x,
                                 input logic b, input logic dn, input logic ps);
        chk({tag, "_sig"}, 32'(sig_out), 32'(s));
        chk({tag, "_vec"}, 32'(vec_count), 32'(v));
        chk({tag, "_x"}, 32'(x_count), 32'(x));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
        chk({tag, "_ready"}, 32'(in_ready), 32'(b));
        chk({tag, "_done"}, 32'(done), 32'(dn));
        chk({tag, "_pass"}, 32'(pass), 32'(ps));
    endtask

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) begin
            #1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL accept: beat accepted with no beat expected, vec_count %0d", vec_count);
            end else begin
                e_mon = q.pop_front();
                chk("beat_sig", 32'(sig_out), 32'(e_mon.sig));
                chk("beat_vec", 32'(vec_count), 32'(e_mon.vec));
                chk("beat_x", 32'(x_count), 32'(e_mon.x));
                chk("beat_done", 32'(done), 32'(e_mon.done));
                chk("beat_pass", 32'(pass), 32'(e_mon.pass));
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        m_sig = S;
        m_vec = 0;
        m_x = 0;
        m_pass = 1'b0;
        check_outputs("start", S, 0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic beat(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data = d;
        m_sig = ref_fold(m_sig, d);
        m_vec++;
        m_x += $isunknown(d) ? 1 : 0;
        if (m_vec == N) begin
            exp_sig = $urandom_range(1) ? m_sig : m_sig ^ W'($urandom_range(1, 255));
            m_pass = (m_sig == exp_sig);
        end
        q.push_back('{m_sig, m_vec, m_x, m_vec == N, m_vec == N ? m_pass : 1'b0});
    endtask

    task automatic run(input int nbeats, input bit directed, input bit allow_x);
        logic [W-1:0] d;
        do_start();
        while (m_vec < nbeats) begin
            start = (m_vec > 0) && ($urandom_range(5) == 0);
            if (directed || $urandom_range(1) == 1) begin
                d = directed ? W'(m_vec + 1) : W'($urandom);
                if (allow_x && $urandom_range(2) == 0) d[$urandom_range(W - 1)] = 1'bx;
                beat(d);
            end else begin
                in_valid = 1'b0;
                in_data = W'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (nbeats == N) begin
            check_outputs("final", m_sig, N, m_x, 1'b0, 1'b1, m_pass);
            in_valid = 1'b1;
            in_data = W'($urandom);
            @(negedge clk);
            check_outputs("hold", m_sig, N, m_x, 1'b0, 1'b1, m_pass);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        #1;
        check_outputs("reset", 8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs("idle", 8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
        run(N, 1'b1, 1'b0);
        for (int r = 0; r < 8; r++) run(N, 1'b0, 1'b1);
        run(2, 1'b0, 1'b1);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_outputs("midrst", 8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) run(N, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
        $fatal(1);
    end
endmodule
